// File: rtl/audio_event_scheduler.sv
// Sound-effect sequencer for the single tone generator: latches four event
// requests, plays the highest-priority one for its duration, then a silent gap.
module audio_event_scheduler #(
    parameter logic [3:0] FREQ_COIN  = 4'hA,
    parameter logic [3:0] FREQ_WALL  = 4'h9,
    parameter logic [3:0] FREQ_GHOST = 4'h5,
    parameter logic [3:0] FREQ_DEATH = 4'h2,
    parameter logic [7:0] DUR_COIN   = 8'd20,
    parameter logic [7:0] DUR_WALL   = 8'd30,
    parameter logic [7:0] DUR_GHOST  = 8'd50,
    parameter logic [7:0] DUR_DEATH  = 8'd200,
    parameter logic [7:0] GAP_TICKS  = 8'd5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       coinReq,
    input  logic       wallReq,
    input  logic       ghostReq,
    input  logic       deathReq,
    output logic       Enable_Sound,
    output logic [3:0] frequency,
    output logic       Enable_Eat,
    output logic       busy,
    output logic [1:0] activeSrc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] pending_r, pending_s;
    logic [7:0] count_r, count_s;
    logic [1:0] src_r, src_s;
    logic [3:0] req_s, cand_s;
    logic [1:0] win_s;
    logic       any_s;
    logic       en_s, eat_s, busy_s;
    logic [3:0] freq_s;
    logic [1:0] asrc_s;

    // A zero duration would never end on a tick, so it plays for one tick.
    function automatic logic [7:0] dur_of(input logic [1:0] s);
        logic [7:0] d;
        case (s)
            2'd0:    d = DUR_COIN;
            2'd1:    d = DUR_WALL;
            2'd2:    d = DUR_GHOST;
            2'd3:    d = DUR_DEATH;
            default: d = DUR_COIN;
        endcase
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    function automatic logic [3:0] freq_of(input logic [1:0] s);
        logic [3:0] f;
        case (s)
            2'd0:    f = FREQ_COIN;
            2'd1:    f = FREQ_WALL;
            2'd2:    f = FREQ_GHOST;
            2'd3:    f = FREQ_DEATH;
            default: f = FREQ_COIN;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    assign req_s  = {deathReq, ghostReq, wallReq, coinReq};
    assign cand_s = pending_r | req_s;

    // Fixed-priority pick: highest source index among pending and live requests.
    always_comb begin
        win_s = 2'd0;
        any_s = 1'b1;
        if (cand_s[3]) begin
            win_s = 2'd3;
        end else if (cand_s[2]) begin
            win_s = 2'd2;
        end else if (cand_s[1]) begin
            win_s = 2'd1;
        end else if (cand_s[0]) begin
            win_s = 2'd0;
        end else begin
            any_s = 1'b0;
        end
    end

    // Next-state, pending, counter and source selection.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        count_s   = count_r;
        src_s     = src_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_s   = ST_PLAY;
                    src_s     = win_s;
                    count_s   = dur_of(win_s);
                    pending_s = cand_s & ~onehot(win_s);
                end else begin
                    count_s = 8'd0;
                    src_s   = 2'd0;
                end
            end
            ST_PLAY: begin
                if (any_s && (win_s > src_r)) begin
                    // Preempted source is dropped, never re-pended.
                    src_s     = win_s;
                    count_s   = dur_of(win_s);
                    pending_s = (pending_r | (req_s & ~onehot(src_r))) & ~onehot(win_s);
                end else begin
                    pending_s = pending_r | (req_s & ~onehot(src_r));
                    if (req_s[src_r]) begin
                        count_s = dur_of(src_r);
                    end else if (tick) begin
                        if (count_r <= 8'd1) begin
                            src_s = 2'd0;
                            if (GAP_TICKS != 8'd0) begin
                                state_s = ST_GAP;
                                count_s = GAP_TICKS;
                            end else begin
                                state_s = ST_IDLE;
                                count_s = 8'd0;
                            end
                        end else begin
                            count_s = count_r - 8'd1;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            ST_GAP: begin
                pending_s = pending_r | req_s;
                if (tick) begin
                    if (count_r <= 8'd1) begin
                        state_s = ST_IDLE;
                        count_s = 8'd0;
                    end else begin
                        count_s = count_r - 8'd1;
                    end
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = 4'd0;
                count_s   = 8'd0;
                src_s     = 2'd0;
            end
        endcase
    end

    // Output values derived from the upcoming state so the ports are registered.
    always_comb begin
        en_s   = 1'b0;
        freq_s = 4'd0;
        eat_s  = 1'b0;
        busy_s = 1'b0;
        asrc_s = 2'd0;
        if (state_s == ST_PLAY) begin
            en_s   = 1'b1;
            freq_s = freq_of(src_s);
            eat_s  = (src_s == 2'd0);
            busy_s = 1'b1;
            asrc_s = src_s;
        end else if (state_s == ST_GAP) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            pending_r    <= 4'd0;
            count_r      <= 8'd0;
            src_r        <= 2'd0;
            Enable_Sound <= 1'b0;
            frequency    <= 4'd0;
            Enable_Eat   <= 1'b0;
            busy         <= 1'b0;
            activeSrc    <= 2'd0;
        end else begin
            state_r      <= state_s;
            pending_r    <= pending_s;
            count_r      <= count_s;
            src_r        <= src_s;
            Enable_Sound <= en_s;
            frequency    <= freq_s;
            Enable_Eat   <= eat_s;
            busy         <= busy_s;
            activeSrc    <= asrc_s;
        end
    end

endmodule

// File: tb/tb_audio_event_scheduler.sv
// Bench for audio_event_scheduler: a default build and a zero-gap build share
// stimulus and are compared every cycle against a behavioural sound-queue model.
module tb_audio_event_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN, tick, coinReq, wallReq, ghostReq, deathReq;
    logic       en_a, eat_a, busy_a, en_b, eat_b, busy_b;
    logic [3:0] freq_a, freq_b;
    logic [1:0] src_a, src_b;

    int compared   = 0;
    int mismatched = 0;

    // Model per build: phase 0 = silent/idle, 1 = sounding, 2 = silent gap.
    int         m_phase [2];
    int         m_src   [2];
    int         m_left  [2];
    logic [3:0] m_pend  [2];
    int         gap_of  [2] = '{5, 0};

    audio_event_scheduler dut (
        .clk(clk), .resetN(resetN), .tick(tick),
        .coinReq(coinReq), .wallReq(wallReq), .ghostReq(ghostReq), .deathReq(deathReq),
        .Enable_Sound(en_a), .frequency(freq_a), .Enable_Eat(eat_a),
        .busy(busy_a), .activeSrc(src_a)
    );

    audio_event_scheduler #(.GAP_TICKS(8'd0)) dut_nogap (
        .clk(clk), .resetN(resetN), .tick(tick),
        .coinReq(coinReq), .wallReq(wallReq), .ghostReq(ghostReq), .deathReq(deathReq),
        .Enable_Sound(en_b), .frequency(freq_b), .Enable_Eat(eat_b),
        .busy(busy_b), .activeSrc(src_b)
    );

    function automatic int dur_tab(input int s);
        case (s)
            0:       return 20;
            1:       return 30;
            2:       return 50;
            default: return 200;
        endcase
    endfunction

    function automatic int freq_tab(input int s);
        case (s)
            0:       return 10;
            1:       return 9;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    function automatic bit has(input logic [3:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_src[k]   = 0;
            m_left[k]  = 0;
            m_pend[k]  = 4'd0;
        end
    endtask

    task automatic model_edge(input int k, input logic [3:0] rq, input logic tk);
        logic [3:0] cand;
        int top;
        cand = m_pend[k] | rq;
        top  = -1;
        for (int i = 0; i < 4; i++) if (has(cand, i)) top = i;
        if (m_phase[k] == 0) begin
            if (top >= 0) begin
                m_phase[k] = 1;
                m_src[k]   = top;
                m_left[k]  = dur_tab(top);
                m_pend[k]  = cand & ~(4'd1 << top);
            end
        end else if (m_phase[k] == 1) begin
            m_pend[k] = (m_pend[k] | rq) & ~(4'd1 << m_src[k]);
            if (top > m_src[k]) begin
                m_pend[k] = m_pend[k] & ~(4'd1 << top);
                m_src[k]  = top;
                m_left[k] = dur_tab(top);
            end else if (has(rq, m_src[k])) begin
                m_left[k] = dur_tab(m_src[k]);
            end else if (tk) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    if (gap_of[k] > 0) begin
                        m_phase[k] = 2;
                        m_left[k]  = gap_of[k];
                    end else begin
                        m_phase[k] = 0;
                    end
                end
            end
        end else begin
            m_pend[k] = m_pend[k] | rq;
            if (tk) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) m_phase[k] = 0;
            end
        end
    endtask

    task automatic check_one(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic       e_en, e_eat, e_busy;
            logic [3:0] e_freq;
            logic [1:0] e_src;
            e_en   = (m_phase[k] == 1);
            e_freq = e_en ? 4'(freq_tab(m_src[k])) : 4'd0;
            e_eat  = e_en && (m_src[k] == 0);
            e_busy = (m_phase[k] != 0);
            e_src  = e_en ? 2'(m_src[k]) : 2'd0;
            if (k == 0) begin
                check_one("gap5.Enable_Sound", {7'd0, en_a}, {7'd0, e_en});
                check_one("gap5.frequency", {4'd0, freq_a}, {4'd0, e_freq});
                check_one("gap5.Enable_Eat", {7'd0, eat_a}, {7'd0, e_eat});
                check_one("gap5.busy", {7'd0, busy_a}, {7'd0, e_busy});
                check_one("gap5.activeSrc", {6'd0, src_a}, {6'd0, e_src});
            end else begin
                check_one("gap0.Enable_Sound", {7'd0, en_b}, {7'd0, e_en});
                check_one("gap0.frequency", {4'd0, freq_b}, {4'd0, e_freq});
                check_one("gap0.Enable_Eat", {7'd0, eat_b}, {7'd0, e_eat});
                check_one("gap0.busy", {7'd0, busy_b}, {7'd0, e_busy});
                check_one("gap0.activeSrc", {6'd0, src_b}, {6'd0, e_src});
            end
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic tk);
        coinReq  = rq[0];
        wallReq  = rq[1];
        ghostReq = rq[2];
        deathReq = rq[3];
        tick     = tk;
        @(posedge clk);
        model_edge(0, rq, tk);
        model_edge(1, rq, tk);
        #1;
        check_all();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b0);
            step(4'b0000, 1'b1);
        end
    endtask

    initial begin
        resetN = 1'b0; tick = 1'b0;
        coinReq = 1'b0; wallReq = 1'b0; ghostReq = 1'b0; deathReq = 1'b0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 resetN = 1'b1;

        // Single coin: 20 ticks of tone, 5 ticks gap.
        step(4'b0001, 1'b0);
        check_one("coin.freq_direct", {4'd0, freq_a}, 8'd10);
        run_ticks(30);

        // Coin and wall together: wall first, coin after the gap.
        step(4'b0011, 1'b0);
        run_ticks(70);

        // Wall preempted by death after 10 ticks.
        step(4'b0010, 1'b0);
        run_ticks(10);
        step(4'b1000, 1'b0);
        check_one("preempt.activeSrc_direct", {6'd0, src_a}, 8'd3);
        run_ticks(210);

        // Coin retriggered after 15 ticks.
        step(4'b0001, 1'b0);
        run_ticks(15);
        step(4'b0001, 1'b0);
        run_ticks(30);

        // Ghost and wall together; the zero-gap build chains them.
        step(4'b0110, 1'b0);
        run_ticks(100);

        // Request during the gap waits for the gap to finish.
        step(4'b0001, 1'b0);
        run_ticks(20);
        step(4'b1000, 1'b1);
        run_ticks(210);

        // Reset in the middle of a coin sound.
        step(4'b0001, 1'b0);
        run_ticks(3);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        run_ticks(30);

        // Randomised traffic with sparse requests and irregular ticks.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] rq;
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, (b == 3) ? 60 : 12) == 0);
            step(rq, 1'($urandom_range(0, 1)));
        end

        // Dense ticks with frequent requests to stress coincident grant/tick.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] rq;
            rq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step(rq, 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/audio_event_scheduler.md
Name: audio_event_scheduler

Overview:
Sequences the game's sound effects onto the single tone generator. Four event sources (coin eaten, wall break, ghost eaten, Pac-Man death) raise one-cycle requests. The block latches them, arbitrates by fixed priority, and drives one frequency code plus enable for a per-source duration. It inserts a silent gap between consecutive sounds and sits between the collision/game-logic blocks and the tone generator.

Parameters:
FREQ_COIN, 4'hA, frequency code for coin sound
FREQ_WALL, 4'h9, frequency code for wall-break sound
FREQ_GHOST, 4'h5, frequency code for ghost-eaten sound
FREQ_DEATH, 4'h2, frequency code for death sound
DUR_COIN, 8'd20, coin duration in ticks
DUR_WALL, 8'd30, wall duration in ticks
DUR_GHOST, 8'd50, ghost duration in ticks
DUR_DEATH, 8'd200, death duration in ticks
GAP_TICKS, 8'd5, silent ticks between sounds; 0 means no gap

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
tick  in  1  one-cycle timebase pulse (e.g. 1 ms); all durations count this
coinReq  in  1  coin event pulse (source 0, lowest priority)
wallReq  in  1  wall-break event pulse (source 1)
ghostReq  in  1  ghost-eaten event pulse (source 2)
deathReq  in  1  death event pulse (source 3, highest priority)
Enable_Sound  out  1  tone generator enable
frequency  out  4  frequency code to tone generator
Enable_Eat  out  1  high while the coin sound plays
busy  out  1  high in PLAY or GAP
activeSrc  out  2  index of the playing source; 0 when not playing

Behaviour:
- Reset (async, resetN=0): state=IDLE, pending=0, counter=0. Enable_Sound=0, frequency=0, Enable_Eat=0, busy=0, activeSrc=0. Reset during PLAY/GAP aborts immediately.
- Requests: pending[3:0] is sticky. A req pulse sets its bit on the edge where it is sampled. A bit clears when its source is granted.
- Candidate set = pending | live req inputs. Winner = highest index in the set.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE: if the set is non-empty, go to PLAY with the winner on that edge. Load counter=DUR_winner and clear the winner's pending bit. A request sampled at the end of cycle n gives Enable_Sound=1 in cycle n+1.
- PLAY: Enable_Sound=1, frequency=FREQ_activeSrc, Enable_Eat=(activeSrc==0), busy=1. Counter decrements on tick.
- PLAY end: tick with counter==1 ends the sound. If GAP_TICKS>0, go to GAP and load counter=GAP_TICKS. If GAP_TICKS=0, go to IDLE-arbitration on that edge, so the next sound can start in the following cycle.
- DUR parameters equal to 0 are treated as 1.
- Preemption: in PLAY, a candidate with strictly higher index than activeSrc restarts PLAY with that source on the next edge. No gap is inserted. The preempted source is dropped, not resumed or re-pended.
- A lower-priority request during PLAY stays pending.
- Same-source re-request during its own PLAY reloads the counter to its DUR (retrigger). The pending bit is not set.
- GAP: Enable_Sound=0, frequency=0, Enable_Eat=0, activeSrc=0, busy=1. Counter decrements on tick. Tick with counter==1 goes to IDLE; IDLE arbitrates the next cycle.
- Requests arriving during GAP pend and are not served until the gap completes. A death request during GAP also waits.
- Simultaneous reqs in one cycle: the highest index wins. The others pend and are served in descending priority, each separated by a gap.
- tick is ignored in IDLE. tick coincident with a grant does not decrement the newly loaded counter.
- Counters are 8-bit unsigned with no wrap: they only decrement while counter>=1.

Test Plan:
- Reset mid-PLAY: coinReq, then resetN=0 for 2 cycles after 3 ticks -> all outputs 0 immediately; pending cleared; no sound after release.
- Single coin: coinReq in cycle n -> cycle n+1: Enable_Sound=1, frequency=4'hA, Enable_Eat=1. Stays on for exactly 20 ticks, then 5 ticks silent with busy=1, then busy=0.
- Simultaneous coinReq+wallReq -> wall plays (4'h9, 30 ticks), 5-tick gap, then coin (4'hA, 20 ticks), then IDLE.
- Preemption: wall playing for 10 ticks, then deathReq -> next cycle frequency=4'h2 and activeSrc=3 for 200 ticks. Wall does not resume.
- Retrigger: coin playing, coinReq at tick 15 -> sound lasts 15+20 ticks total. pending stays 0.
- GAP_TICKS=0 build: ghostReq and wallReq in the same cycle -> ghost 50 ticks, then wall starts the cycle after ghost ends with no Enable_Sound low gap beyond one cycle.
